// File: rtl/pp_column_loader.sv
// Serial loader for a partial-product column array: each beat shifts one bit into every
// column, and after N beats the whole triangular frame is presented to the compressor.
//
// state   | meaning
// S_EMPTY | no beats held, fill_count = 0
// S_FILL  | partial frame, fill_count = 1..N-1
// S_FULL  | complete frame on cols_flat, waiting for out_ready
module pp_column_loader #(
    parameter int N            = 31,
    parameter bit CLEAR_ON_POP = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2*N-2:0]             din,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N*N-1:0]             cols_flat,
    output logic [$clog2(N+1)-1:0]     fill_count
);

    localparam int COLS  = 2*N - 1;
    localparam int TOTAL = N*N;
    localparam int CW    = $clog2(N+1);

    function automatic int col_depth(input int i);
        return (i + 1 < 2*N - 1 - i) ? i + 1 : 2*N - 1 - i;
    endfunction

    function automatic int col_offset(input int i);
        int s;
        s = 0;
        for (int k = 0; k < i; k++) s += col_depth(k);
        return s;
    endfunction

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FILL  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [CW-1:0]     fill_next;
    logic [TOTAL-1:0]  store, store_next;
    logic [TOTAL-1:0]  shift_base, shifted;
    logic              push, pop;

    assign out_valid = (state == S_FULL);
    assign in_ready  = !flush && (!out_valid || out_ready);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign cols_flat = store;

    // A frame being popped in the same cycle is wiped before the new beat lands.
    assign shift_base = (pop && CLEAR_ON_POP) ? '0 : store;

    for (genvar i = 0; i < COLS; i++) begin : g_col
        localparam int D = col_depth(i);
        localparam int O = col_offset(i);
        if (D == 1) begin : g_single
            assign shifted[O] = din[i];
        end else begin : g_multi
            assign shifted[O+D-1:O] = {shift_base[O+D-2:O], din[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_EMPTY;
            fill_count <= '0;
            store      <= '0;
        end else begin
            state      <= state_next;
            fill_count <= fill_next;
            store      <= store_next;
        end
    end

    always_comb begin
        fill_next  = fill_count;
        store_next = store;
        if (flush) begin
            fill_next  = '0;
            store_next = '0;
        end else if (push) begin
            store_next = shifted;
            fill_next  = pop ? CW'(1) : fill_count + CW'(1);
        end else if (pop) begin
            fill_next = '0;
            if (CLEAR_ON_POP) store_next = '0;
        end

        // State is a pure function of the beat count so the two can never disagree.
        if (fill_next == '0)
            state_next = S_EMPTY;
        else if (fill_next == CW'(N))
            state_next = S_FULL;
        else
            state_next = S_FILL;
    end

endmodule

// File: tb/tb_pp_column_loader.sv
// Bench for pp_column_loader: directed N=3 cases on both clear modes, then a randomized
// N=31 run scored against a beat-history model of the column array.
module tb_pp_column_loader;

    localparam int NR    = 31;
    localparam int COLSR = 2*NR - 1;
    localparam int TOTR  = NR*NR;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // N=3 pair sharing one stimulus
    logic       d_flush = 0, d_iv = 0, d_ordy = 0;
    logic [4:0] d_din = '0;
    logic       a_ir, a_ov, b_ir, b_ov;
    logic [8:0] a_cols, b_cols;
    logic [1:0] a_fc, b_fc;

    pp_column_loader #(.N(3), .CLEAR_ON_POP(1'b1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .flush(d_flush), .in_valid(d_iv), .in_ready(a_ir),
        .din(d_din), .out_valid(a_ov), .out_ready(d_ordy), .cols_flat(a_cols), .fill_count(a_fc));

    pp_column_loader #(.N(3), .CLEAR_ON_POP(1'b0)) u_c0 (
        .clk(clk), .rst_n(rst_n), .flush(d_flush), .in_valid(d_iv), .in_ready(b_ir),
        .din(d_din), .out_valid(b_ov), .out_ready(d_ordy), .cols_flat(b_cols), .fill_count(b_fc));

    // N=31 randomized instance
    logic             r_flush = 0, r_iv = 0, r_ordy = 0;
    logic [COLSR-1:0] r_din = '0;
    logic             r_ir, r_ov;
    logic [TOTR-1:0]  r_cols;
    logic [4:0]       r_fc;

    pp_column_loader #(.N(NR), .CLEAR_ON_POP(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(r_flush), .in_valid(r_iv), .in_ready(r_ir),
        .din(r_din), .out_valid(r_ov), .out_ready(r_ordy), .cols_flat(r_cols), .fill_count(r_fc));

    task automatic cyc3(input logic iv, input logic [4:0] din, input logic ordy, input logic fl);
        @(negedge clk);
        d_iv = iv; d_din = din; d_ordy = ordy; d_flush = fl;
        @(posedge clk);
        #1;
    endtask

    // Reference: a frame is just the last N accepted beats; column i bit j is beat (N-1-j).
    logic [COLSR-1:0] beats[$];

    function automatic int depth_of(input int i);
        return (i < NR) ? i + 1 : 2*NR - 1 - i;
    endfunction

    function automatic logic [63:0] exp_col(input int i);
        logic [63:0] v;
        logic [COLSR-1:0] b;
        v = '0;
        for (int j = 0; j < depth_of(i); j++) begin
            b = beats[NR-1-j];
            v[j] = b[i];
        end
        return v;
    endfunction

    function automatic logic [63:0] dut_col(input int i, input int off);
        logic [63:0] v;
        v = '0;
        for (int j = 0; j < depth_of(i); j++) v[j] = r_cols[off+j];
        return v;
    endfunction

    initial begin
        logic [63:0] rnd;
        logic        exp_full, exp_ir, do_pop;
        int          pops, off, accepted, popped_beats;

        #3;
        chk("rst_in_ready", a_ir, 1'b1);
        chk("rst_cols", a_cols, 9'h000);
        chk("rst_fc", a_fc, 2'd0);
        chk("rst_out_valid", a_ov, 1'b0);
        chk("rst_in_ready_n31", r_ir, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 1; k <= 3; k++) begin
            cyc3(1'b1, 5'h1F, 1'b0, 1'b0);
            chk("fill_fc_c1", a_fc, k);
            chk("fill_fc_c0", b_fc, k);
        end
        chk("full_out_valid", a_ov, 1'b1);
        chk("full_cols_c1", a_cols, 9'h1FF);
        chk("full_cols_c0", b_cols, 9'h1FF);
        chk("full_in_ready", a_ir, 1'b0);

        cyc3(1'b1, 5'h00, 1'b0, 1'b0);
        chk("hold_cols", a_cols, 9'h1FF);
        chk("hold_fc", a_fc, 2'd3);

        cyc3(1'b1, 5'h01, 1'b1, 1'b0);
        chk("poppush_fc_c1", a_fc, 2'd1);
        chk("poppush_ov_c1", a_ov, 1'b0);
        chk("poppush_cols_c1", a_cols, 9'h001);
        chk("poppush_fc_c0", b_fc, 2'd1);
        // Retained ones shifted left once with din=00001
        chk("poppush_cols_c0", b_cols, 9'h0B5);

        cyc3(1'b1, 5'h02, 1'b0, 1'b0);
        chk("pre_flush_fc", a_fc, 2'd2);
        @(negedge clk);
        d_iv = 1'b1; d_din = 5'h1F; d_flush = 1'b1;
        #1;
        chk("flush_in_ready", a_ir, 1'b0);
        @(posedge clk);
        #1;
        chk("flush_fc", a_fc, 2'd0);
        chk("flush_cols_c1", a_cols, 9'h000);
        chk("flush_cols_c0", b_cols, 9'h000);
        chk("flush_ov", a_ov, 1'b0);

        cyc3(1'b1, 5'h01, 1'b0, 1'b0);
        cyc3(1'b1, 5'h02, 1'b0, 1'b0);
        cyc3(1'b1, 5'h04, 1'b0, 1'b0);
        chk("fresh_cols_c1", a_cols, 9'h00C);
        chk("fresh_cols_c0", b_cols, 9'h00C);
        chk("fresh_ov", a_ov, 1'b1);

        cyc3(1'b0, 5'h00, 1'b1, 1'b0);
        chk("pop_fc", a_fc, 2'd0);
        chk("pop_cols_c1", a_cols, 9'h000);
        chk("pop_cols_c0", b_cols, 9'h00C);
        chk("pop_ov_c0", b_ov, 1'b0);
        cyc3(1'b0, 5'h00, 1'b0, 1'b0);

        pops = 0;
        accepted = 0;
        popped_beats = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (cyc == 700 || cyc == 1400) begin
                rst_n = 1'b0;
                #1;
                chk("midrst_cols", (r_cols == '0), 1'b1);
                chk("midrst_fc", r_fc, 5'd0);
                chk("midrst_ov", r_ov, 1'b0);
                accepted -= beats.size();
                beats.delete();
                @(negedge clk);
                rst_n = 1'b1;
            end
            r_iv    = ($urandom_range(3) != 0);
            r_ordy  = $urandom_range(1);
            r_flush = ($urandom_range(31) == 0);
            rnd     = {$urandom, $urandom};
            r_din   = rnd[COLSR-1:0];
            #1;
            exp_full = (beats.size() == NR);
            exp_ir   = !r_flush && (!exp_full || r_ordy);
            do_pop   = exp_full && r_ordy && !r_flush;
            chk("rnd_in_ready", r_ir, exp_ir);
            chk("rnd_out_valid", r_ov, exp_full);
            chk("rnd_fc", r_fc, beats.size());
            chk("rnd_fc_bound", (r_fc <= 5'd31), 1'b1);
            if (do_pop) begin
                off = 0;
                for (int i = 0; i < COLSR; i++) begin
                    if (dut_col(i, off) !== exp_col(i))
                        $display("  column %0d differs", i);
                    chk("frame_col", dut_col(i, off), exp_col(i));
                    off += depth_of(i);
                end
                pops++;
                popped_beats += NR;
            end
            if (r_flush) begin
                accepted -= beats.size();
                beats.delete();
            end else begin
                if (do_pop) beats.delete();
                if (r_iv && exp_ir) begin
                    beats.push_back(r_din);
                    accepted++;
                end
            end
        end
        @(negedge clk);
        r_iv = 1'b0; r_flush = 1'b0; r_ordy = 1'b0;
        chk("frames_popped", (pops > 0), 1'b1);
        chk("beat_accounting", accepted, popped_beats + beats.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
